seg7_capture: RTL and testbench

Passive reader for the board's multiplexed 4-digit 7-segment bus. It samples the segment lines and active-low digit enables that the display driver produces, waits for each pattern to settle, decodes it back to a hex nibble, and assembles a 16-bit value. It sits beside the display driver on the same FPGA nets for loopback self-test and debug, and exposes per-digit status plus a frame strobe.

---
 rtl/seg7_capture_if.sv | 26 ++
 rtl/seg7_capture.sv | 162 ++++++++++++++++
 tb/tb_seg7_capture.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
`default_nettype none
// ============================================================================
// Module : seg7_capture_if
// Desc   : 7-segment bus signals seen by the capture block, plus its results.
// Rev    : 1.0
// ============================================================================
interface seg7_capture_if;
    logic [6:0]  SEG;
    logic [3:0]  DS_EN;
    logic [15:0] VALUE;
    logic [3:0]  DIG_VALID;
    logic [3:0]  BLANK;
    logic        ERR;
    logic        FRAME_STB;

    modport master (
        output SEG, DS_EN,
        input  VALUE, DIG_VALID, BLANK, ERR, FRAME_STB
    );

    modport slave (
        input  SEG, DS_EN,
        output VALUE, DIG_VALID, BLANK, ERR, FRAME_STB
    );
endinterface
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
// Module : seg7_capture
// Desc   : Passive reader of a multiplexed 4-digit 7-segment bus.
// Rev    : 1.0
// ============================================================================
module seg7_capture #(
    parameter int STABLE_CYC = 16
) (
    input  logic          CLK,
    input  logic          RST,
    seg7_capture_if.slave bus
);

    localparam int                 c_cnt_w      = $clog2(STABLE_CYC) + 1;
    localparam logic [c_cnt_w-1:0] c_accept_cnt = c_cnt_w'(STABLE_CYC - 1);
    localparam logic [0:0]         c_st_collect = 1'b0;
    localparam logic [0:0]         c_st_strobe  = 1'b1;

    logic [10:0]        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [15:0]        value_q, value_d;
    logic [3:0]         dig_valid_q, dig_valid_d;
    logic [3:0]         blank_q, blank_d;
    logic [3:0]         mask_q, mask_d;
    logic               err_q, err_d;
    logic [0:0]         state_q, state_d;
    logic               frame_stb;

    logic [6:0] w_seg;
    logic [3:0] w_ds;
    logic [3:0] w_wr;
    logic [4:0] w_dec;
    logic       w_change, w_accept, w_legal;

    // Returns {decodable, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0111111: decode = 5'h10;
            7'b0000110: decode = 5'h11;
            7'b1011011: decode = 5'h12;
            7'b1001111: decode = 5'h13;
            7'b1100110: decode = 5'h14;
            7'b1101101: decode = 5'h15;
            7'b1111101: decode = 5'h16;
            7'b0000111: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1101111: decode = 5'h19;
            7'b1110111: decode = 5'h1A;
            7'b1111100: decode = 5'h1B;
            7'b1011000: decode = 5'h1C;
            7'b1011110: decode = 5'h1D;
            7'b1111001: decode = 5'h1E;
            7'b1110001: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        w_seg    = sync2_q[10:4];
        w_ds     = sync2_q[3:0];
        w_change = (sync2_q != prev_q);
        w_accept = !w_change && (cnt_q == c_accept_cnt);
        w_legal  = $onehot(~w_ds) || (w_ds == 4'b0000);
        w_wr     = (w_accept && w_legal) ? ~w_ds : 4'b0000;
        w_dec    = decode(w_seg);
    end

    always_comb begin
        sync1_d     = {bus.SEG, bus.DS_EN};
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        value_d     = value_q;
        dig_valid_d = dig_valid_q;
        blank_d     = blank_q;
        err_d       = 1'b0;

        if (w_change)
            cnt_d = '0;
        else if (cnt_q != {c_cnt_w{1'b1}})
            cnt_d = cnt_q + c_cnt_w'(1);
        else
            cnt_d = cnt_q;

        if (w_accept && !w_legal && (w_ds != 4'b1111))
            err_d = 1'b1;
        if ((w_wr != 4'b0000) && !w_dec[4] && (w_seg != 7'b0000000))
            err_d = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (w_wr[i]) begin
                if (w_dec[4]) begin
                    value_d[4*i +: 4] = w_dec[3:0];
                    dig_valid_d[i]    = 1'b1;
                    blank_d[i]        = 1'b0;
                end else if (w_seg == 7'b0000000) begin
                    value_d[4*i +: 4] = 4'h0;
                    dig_valid_d[i]    = 1'b0;
                    blank_d[i]        = 1'b1;
                end else begin
                    dig_valid_d[i]    = 1'b0;
                    blank_d[i]        = 1'b0;
                end
            end
        end

        // The strobe cycle clears the mask but still records a coincident write
        mask_d = (state_q == c_st_strobe) ? w_wr : (mask_q | w_wr);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q     <= {7'b0000000, 4'b1111};
            sync2_q     <= {7'b0000000, 4'b1111};
            prev_q      <= {7'b0000000, 4'b1111};
            cnt_q       <= '0;
            value_q     <= 16'h0000;
            dig_valid_q <= 4'b0000;
            blank_q     <= 4'b0000;
            mask_q      <= 4'b0000;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            dig_valid_q <= dig_valid_d;
            blank_q     <= blank_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= c_st_collect;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_collect: if (mask_q == 4'b1111) state_d = c_st_strobe;
            c_st_strobe:  state_d = c_st_collect;
            default:      state_d = c_st_collect;
        endcase
    end

    always_comb begin
        frame_stb = (state_q == c_st_strobe);
    end

    assign bus.VALUE     = value_q;
    assign bus.DIG_VALID = dig_valid_q;
    assign bus.BLANK     = blank_q;
    assign bus.ERR       = err_q;
    assign bus.FRAME_STB = frame_stb;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_seg7_capture
// Desc   : Self-checking bench for seg7_capture (vector table + scoreboard).
// Rev    : 1.0
// ============================================================================
module tb_seg7_capture;

    localparam int S = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   err_cnt = 0;
    int   frm_cnt = 0;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYC(S)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  ds;
        logic [6:0]  seg;
        int          hold;
        bit          chk;
        logic [15:0] v;
        logic [3:0]  vld;
        logic [3:0]  blk;
        bit          err;
        bit          frm;
    } vec_t;

    typedef struct {
        int          idx;
        int          due;
        logic [15:0] prev_v;
        logic [15:0] v;
        logic [3:0]  vld;
        logic [3:0]  blk;
        bit          err;
        bit          frm;
    } sb_t;

    vec_t tbl [16];
    sb_t  sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.ERR === 1'b1) err_cnt++;
        if (bus.FRAME_STB === 1'b1) frm_cnt++;
    end

    always @(negedge CLK) begin
        if (sb.size() != 0) begin
            if (cyc == sb[0].due - 1) begin
                chk($sformatf("early_value[%0d]", sb[0].idx), 32'(bus.VALUE), 32'(sb[0].prev_v));
                chk($sformatf("early_err[%0d]", sb[0].idx), 32'(bus.ERR), 32'(0));
            end
            if (cyc == sb[0].due) begin
                chk($sformatf("value[%0d]", sb[0].idx), 32'(bus.VALUE), 32'(sb[0].v));
                chk($sformatf("dig_valid[%0d]", sb[0].idx), 32'(bus.DIG_VALID), 32'(sb[0].vld));
                chk($sformatf("blank[%0d]", sb[0].idx), 32'(bus.BLANK), 32'(sb[0].blk));
                chk($sformatf("err[%0d]", sb[0].idx), 32'(bus.ERR), 32'(sb[0].err));
            end
            if (cyc == sb[0].due + 1) begin
                chk($sformatf("frame_stb[%0d]", sb[0].idx), 32'(bus.FRAME_STB), 32'(sb[0].frm));
                chk($sformatf("err_width[%0d]", sb[0].idx), 32'(bus.ERR), 32'(0));
                void'(sb.pop_front());
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge CLK);
        #1;
        chk("scoreboard_drain", 32'(sb.size()), 32'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_value"}, 32'(bus.VALUE), 32'(0));
        chk({tag, "_dig_valid"}, 32'(bus.DIG_VALID), 32'(0));
        chk({tag, "_blank"}, 32'(bus.BLANK), 32'(0));
        chk({tag, "_err"}, 32'(bus.ERR), 32'(0));
        chk({tag, "_frame_stb"}, 32'(bus.FRAME_STB), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, f0;
        logic [15:0] prev;

        tbl[0]  = '{4'b0111, 7'b0000110, 20, 1'b1, 16'h1000, 4'b1000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b1011, 7'b1011011, 20, 1'b1, 16'h1200, 4'b1100, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'b1101, 7'b1001111, 20, 1'b1, 16'h1230, 4'b1110, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b1110, 7'b1110001, 20, 1'b1, 16'h123F, 4'b1111, 4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{4'b0111, 7'b1111111, 10, 1'b0, 16'h123F, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{4'b1111, 7'b1111111, 20, 1'b1, 16'h123F, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b1011, 7'b1000000, 20, 1'b1, 16'h123F, 4'b1011, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{4'b0011, 7'b0111111, 20, 1'b1, 16'h123F, 4'b1011, 4'b0000, 1'b1, 1'b0};
        tbl[8]  = '{4'b0000, 7'b1110111, 20, 1'b1, 16'hAAAA, 4'b1111, 4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{4'b1110, 7'b0000000, 20, 1'b1, 16'hAAA0, 4'b1110, 4'b0001, 1'b0, 1'b0};
        tbl[10] = '{4'b1101, 7'b1111100, 20, 1'b1, 16'hAAB0, 4'b1110, 4'b0001, 1'b0, 1'b0};
        tbl[11] = '{4'b1110, 7'b1011110, 20, 1'b1, 16'hAABD, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{4'b0111, 7'b1011000, 20, 1'b1, 16'hCABD, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[13] = '{4'b1011, 7'b1111001, 20, 1'b1, 16'hCEBD, 4'b1111, 4'b0000, 1'b0, 1'b1};
        tbl[14] = '{4'b0000, 7'b1000000, 20, 1'b1, 16'hCEBD, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tbl[15] = '{4'b1111, 7'b0000000, 20, 1'b1, 16'hCEBD, 4'b0000, 4'b0000, 1'b0, 1'b0};

        bus.SEG   = 7'b0000000;
        bus.DS_EN = 4'b1111;
        RST       = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_zero("reset");
        RST = 1'b0;

        e0 = err_cnt;
        f0 = frm_cnt;
        repeat (1000) @(posedge CLK);
        #1;
        chk("idle_err_pulses", 32'(err_cnt - e0), 32'(0));
        chk("idle_frame_pulses", 32'(frm_cnt - f0), 32'(0));

        prev = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            bus.DS_EN = tbl[i].ds;
            bus.SEG   = tbl[i].seg;
            if (tbl[i].chk)
                sb.push_back('{i, cyc + S + 3, prev, tbl[i].v, tbl[i].vld,
                               tbl[i].blk, tbl[i].err, tbl[i].frm});
            prev = tbl[i].v;
            repeat (tbl[i].hold) @(posedge CLK);
            #1;
        end
        drain();
        chk("total_err_pulses", 32'(err_cnt - e0), 32'(3));
        chk("total_frame_pulses", 32'(frm_cnt - f0), 32'(4));

        // Asynchronous reset between clock edges, then a fresh settle
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        bus.DS_EN = 4'b1011;
        bus.SEG   = 7'b1101101;
        sb.push_back('{100, cyc + S + 3, 16'h0000, 16'h0500, 4'b0100, 4'b0000, 1'b0, 1'b0});
        repeat (25) @(posedge CLK);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
